adder_result_checker: RTL

Synthesizable response checker for the ripple-carry adder. It sits at the output end of the adder interface. It samples each applied vector together with the adder's `sum`/`c_out`, recomputes the expected result, and counts vectors and mismatches. It captures the first failing vector and reports pass/fail after a fixed number of vectors, for on-board self-test and as the scoreboard in adder benches.

---
 rtl/adder_result_checker_if.sv | 42 ++++
 rtl/adder_result_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : adder_result_checker_if
// Brief   : Vector/result bundle between an adder test driver and the checker.
// Revision: 1.0 - initial release
// ============================================================================
interface adder_result_checker_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
);
  logic             start;
  logic             vec_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic             fail_cin;
  logic [WIDTH-1:0] fail_sum;
  logic             fail_cout;

  modport master (
    output start, vec_valid, a, b, c_in, sum, c_out,
    input  busy, done, pass, vec_count, err_count,
    input  fail_valid, fail_a, fail_b, fail_cin, fail_sum, fail_cout
  );

  modport slave (
    input  start, vec_valid, a, b, c_in, sum, c_out,
    output busy, done, pass, vec_count, err_count,
    output fail_valid, fail_a, fail_b, fail_cin, fail_sum, fail_cout
  );
endinterface
`default_nettype wire

// File: rtl/adder_result_checker.sv
`default_nettype none
// ============================================================================
// Module  : adder_result_checker
// Brief   : Two-stage response checker for a ripple-carry adder with counters,
//           first-failure capture and pass/fail after NUM_VECTORS compares.
// Revision: 1.0 - initial release
// ============================================================================
module adder_result_checker #(
  parameter int WIDTH       = 2,
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  wire                   clk,
  input  wire                   rst_n,
  adder_result_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_NUM_VEC = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_accepted;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;
  logic [WIDTH-1:0] r_s1_sum;
  logic             r_s1_cout;

  logic [CNT_W-1:0] r_vec_count;
  logic [CNT_W-1:0] r_err_count;
  logic             r_fail_valid;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic             r_fail_cin;
  logic [WIDTH-1:0] r_fail_sum;
  logic             r_fail_cout;

  logic [WIDTH:0]   w_expected;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_err_next;
  logic             w_last_cmp;
  logic             w_accept;

  assign w_expected = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{WIDTH{1'b0}}, r_s1_cin};
  assign w_mismatch = (w_expected != {r_s1_cout, r_s1_sum});
  assign w_err_next = (w_mismatch && (r_err_count != C_CNT_MAX))
                      ? r_err_count + CNT_W'(1) : r_err_count;
  assign w_last_cmp = (r_vec_count == C_NUM_VEC - CNT_W'(1));
  assign w_accept   = bus.vec_valid && (r_accepted < C_NUM_VEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_accepted   <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_cin     <= 1'b0;
      r_s1_sum     <= '0;
      r_s1_cout    <= 1'b0;
      r_vec_count  <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
      r_fail_cin   <= 1'b0;
      r_fail_sum   <= '0;
      r_fail_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_s1_valid <= 1'b0;
          if (bus.start) begin
            // Entering a run wipes every result of the previous one.
            r_state      <= S_RUN;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_accepted   <= '0;
            r_vec_count  <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_cin   <= 1'b0;
            r_fail_sum   <= '0;
            r_fail_cout  <= 1'b0;
          end
        end

        S_RUN: begin
          r_s1_valid <= w_accept;
          if (w_accept) begin
            r_accepted <= r_accepted + CNT_W'(1);
            r_s1_a     <= bus.a;
            r_s1_b     <= bus.b;
            r_s1_cin   <= bus.c_in;
            r_s1_sum   <= bus.sum;
            r_s1_cout  <= bus.c_out;
          end

          if (r_s1_valid) begin
            r_vec_count <= r_vec_count + CNT_W'(1);
            r_err_count <= w_err_next;
            // Only the first failing vector of a run is kept.
            if (w_mismatch && !r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_a     <= r_s1_a;
              r_fail_b     <= r_s1_b;
              r_fail_cin   <= r_s1_cin;
              r_fail_sum   <= r_s1_sum;
              r_fail_cout  <= r_s1_cout;
            end
            if (w_last_cmp) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_pass     <= 1'b0;
          r_s1_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.vec_count  = r_vec_count;
  assign bus.err_count  = r_err_count;
  assign bus.fail_valid = r_fail_valid;
  assign bus.fail_a     = r_fail_a;
  assign bus.fail_b     = r_fail_b;
  assign bus.fail_cin   = r_fail_cin;
  assign bus.fail_sum   = r_fail_sum;
  assign bus.fail_cout  = r_fail_cout;

endmodule
`default_nettype wire
